// File: rtl/icache_dm_pkg.sv
// icache_dm_pkg: shared widths, cache geometry defaults, NOP encoding and refill FSM states.
package icache_dm_pkg;
  localparam int DATA_W = 64;
  localparam int INSTR_W = 32;
  localparam int ICACHE_LINES = 16;
  localparam int ICACHE_WORDS = 4;
  localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h00000013;
  typedef enum logic [1:0] {
    IC_IDLE   = 2'd0,
    IC_REFILL = 2'd1,
    IC_FILLED = 2'd2
  } ic_state_e;
endpackage

// File: rtl/icache_dm_if.sv
// icache_dm_if: fetch-side and backing-memory signals of the instruction cache.
interface icache_dm_if;
  import icache_dm_pkg::*;
  logic [DATA_W-1:0]  PCF;
  logic [INSTR_W-1:0] instrF;
  logic               stallICache;
  logic               invalidate;
  logic               memReq;
  logic [DATA_W-1:0]  memAddr;
  logic               memReady;
  logic [INSTR_W-1:0] memRData;
  modport master (
    output PCF, invalidate, memReady, memRData,
    input  instrF, stallICache, memReq, memAddr
  );
  modport slave (
    input  PCF, invalidate, memReady, memRData,
    output instrF, stallICache, memReq, memAddr
  );
endinterface

// File: rtl/icache_refill_fsm.sv
// icache_refill_fsm: sequences line refills, word 0 upward, with registered request/address.
module icache_refill_fsm import icache_dm_pkg::*; #(
  parameter int WORDS_PER_LINE = ICACHE_WORDS,
  parameter int OFFB = $clog2(WORDS_PER_LINE) + 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     miss_i,
  input  logic [DATA_W-OFFB-1:0]   line_i,
  input  logic                     invalidate_i,
  input  logic                     mem_ready_i,
  output ic_state_e                state_o,
  output logic [$clog2(WORDS_PER_LINE)-1:0] beat_o,
  output logic [DATA_W-OFFB-1:0]   line_o,
  output logic                     discard_o,
  output logic                     accept_o,
  output logic                     last_o,
  output logic                     mem_req_o,
  output logic [DATA_W-1:0]        mem_addr_o
);
  localparam int WB = $clog2(WORDS_PER_LINE);
  ic_state_e              state_q, state_d;
  logic [WB-1:0]          beat_q, beat_d;
  logic [DATA_W-OFFB-1:0] line_q, line_d;
  logic                   discard_q, discard_d;
  logic                   mem_req_q, mem_req_d;
  logic [DATA_W-1:0]      mem_addr_q, mem_addr_d;

  assign accept_o = state_q == IC_REFILL && mem_req_q && mem_ready_i;
  assign last_o = beat_q == WB'(WORDS_PER_LINE - 1);
  assign state_o = state_q;
  assign beat_o = beat_q;
  assign line_o = line_q;
  assign discard_o = discard_q;
  assign mem_req_o = mem_req_q;
  assign mem_addr_o = mem_addr_q;

  always_comb begin
    state_d = state_q;
    beat_d = beat_q;
    line_d = line_q;
    discard_d = discard_q;
    mem_req_d = mem_req_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IC_IDLE: if (miss_i) begin
        state_d = IC_REFILL;
        line_d = line_i;
        beat_d = '0;
        mem_req_d = 1'b1;
        mem_addr_d = {line_i, {OFFB{1'b0}}};
      end
      IC_REFILL: begin
        discard_d = discard_q | invalidate_i;
        if (accept_o && last_o) begin
          state_d = IC_FILLED;
          mem_req_d = 1'b0;
          discard_d = 1'b0;
        end else if (accept_o) begin
          beat_d = beat_q + 1'b1;
          mem_addr_d = {line_q, {OFFB{1'b0}}} + DATA_W'({beat_d, 2'b00});
        end
      end
      IC_FILLED: state_d = IC_IDLE;
      default: state_d = IC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IC_IDLE;
      beat_q <= '0;
      line_q <= '0;
      discard_q <= 1'b0;
      mem_req_q <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      line_q <= line_d;
      discard_q <= discard_d;
      mem_req_q <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end
endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache with same-cycle hits and stalling line refills.
module icache_dm import icache_dm_pkg::*; #(
  parameter int LINES = ICACHE_LINES,
  parameter int WORDS_PER_LINE = ICACHE_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  icache_dm_if.slave  bus
);
  localparam int IDXB = $clog2(LINES);
  localparam int WB = $clog2(WORDS_PER_LINE);
  localparam int OFFB = WB + 2;
  localparam int TAGB = DATA_W - OFFB - IDXB;

  logic [LINES-1:0]   valid_q;
  logic [TAGB-1:0]    tag_q [LINES];
  logic [INSTR_W-1:0] data_q [LINES][WORDS_PER_LINE];

  ic_state_e              state;
  logic [WB-1:0]          beat;
  logic [DATA_W-OFFB-1:0] line;
  logic                   discard, accept, last;
  logic [IDXB-1:0]        idx, line_idx;
  logic [WB-1:0]          off;
  logic [TAGB-1:0]        tag;
  logic                   match, hit;
  logic                   unused_ok;

  assign idx = bus.PCF[OFFB+IDXB-1:OFFB];
  assign off = bus.PCF[OFFB-1:2];
  assign tag = bus.PCF[DATA_W-1:OFFB+IDXB];
  assign line_idx = line[IDXB-1:0];
  assign unused_ok = ^bus.PCF[1:0];

  assign match = valid_q[idx] && tag_q[idx] == tag;
  assign hit = match && state == IC_IDLE;
  assign bus.instrF = hit ? data_q[idx][off] : INSTR_NOP;
  assign bus.stallICache = !reset && !hit;

  icache_refill_fsm #(.WORDS_PER_LINE(WORDS_PER_LINE), .OFFB(OFFB)) u_fsm (
    .clk          (clk),
    .reset        (reset),
    .miss_i       (!match),
    .line_i       (bus.PCF[DATA_W-1:OFFB]),
    .invalidate_i (bus.invalidate),
    .mem_ready_i  (bus.memReady),
    .state_o      (state),
    .beat_o       (beat),
    .line_o       (line),
    .discard_o    (discard),
    .accept_o     (accept),
    .last_o       (last),
    .mem_req_o    (bus.memReq),
    .mem_addr_o   (bus.memAddr)
  );

  // An invalidate coinciding with the final beat must still leave the line invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= '0;
    else begin
      if (bus.invalidate) valid_q <= '0;
      if (accept && last) valid_q[line_idx] <= !discard && !bus.invalidate;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) data_q[line_idx][beat] <= bus.memRData;
    if (accept && last) tag_q[line_idx] <= line[DATA_W-OFFB-1:IDXB];
  end
endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: scoreboard bench for the direct-mapped instruction cache.
module tb_icache_dm;
  import icache_dm_pkg::*;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  int beats = 0;
  logic [31:0] exp_q[$];
  logic [63:0] addr_q[$];
  logic wait_pend = 1'b0;
  logic [63:0] wait_addr;
  logic [31:0] salt = 32'h5a3c_0000;

  icache_dm_if bus();
  icache_dm dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h0001_0001) ^ salt;
  endfunction

  assign bus.memRData = mem_word(bus.memAddr);

  always @(negedge clk) begin
    if (!reset && wait_pend) begin
      total++;
      if (!(bus.memReq === 1'b1 && bus.memAddr === wait_addr)) begin
        bad++;
        $display("FAIL addr_hold: req=%b addr=%h required req=1 addr=%h", bus.memReq, bus.memAddr, wait_addr);
      end
    end
    wait_pend = !reset && bus.memReq && !bus.memReady;
    wait_addr = bus.memAddr;
    if (!reset && bus.memReq && bus.memReady) begin
      beats++;
      total++;
      if (addr_q.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected: addr=%h required no beat", bus.memAddr);
      end else begin
        logic [63:0] a;
        a = addr_q.pop_front();
        if (bus.memAddr !== a) begin
          bad++;
          $display("FAIL beat_addr: got %h required %h", bus.memAddr, a);
        end
      end
    end
  end

  task automatic access(input logic [63:0] pc, input int exp_stall, input int exp_beats,
                        input logic [3:0] pat, input int inv_cyc);
    int c;
    int b0;
    logic [31:0] e;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.PCF = pc;
    exp_q.push_back(mem_word({pc[63:2], 2'b00}));
    for (int k = 0; k < exp_beats; k++) addr_q.push_back({pc[63:4], 4'h0} + 64'(4 * (k % 4)));
    b0 = beats;
    c = 0;
    forever begin
      bus.memReady = pat[c % 4];
      bus.invalidate = (c == inv_cyc);
      @(negedge clk);
      if (!bus.stallICache || c >= 100) break;
      c++;
      @(posedge clk); #1;
    end
    total++;
    if (c !== exp_stall) begin
      bad++;
      $display("FAIL stall_cycles pc=%h: got %0d required %0d", pc, c, exp_stall);
    end
    e = exp_q.pop_front();
    total++;
    if (bus.instrF !== e) begin
      bad++;
      $display("FAIL instr pc=%h: got %h required %h", pc, bus.instrF, e);
    end
    total++;
    if (beats - b0 !== exp_beats) begin
      bad++;
      $display("FAIL beat_count pc=%h: got %0d required %0d", pc, beats - b0, exp_beats);
    end
    total++;
    if (addr_q.size() != 0) begin
      bad++;
      $display("FAIL beats_left pc=%h: got %0d required 0", pc, addr_q.size());
    end
    addr_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.PCF = 64'h0;
    bus.memReady = 1'b0;
    bus.invalidate = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.stallICache !== 1'b0 || bus.instrF !== 32'h00000013) begin
      bad++;
      $display("FAIL reset_out: stall=%b instr=%h required stall=0 instr=00000013", bus.stallICache, bus.instrF);
    end
    total++;
    if (bus.memReq !== 1'b0 || bus.memAddr !== 64'h0) begin
      bad++;
      $display("FAIL reset_mem: req=%b addr=%h required 0 0", bus.memReq, bus.memAddr);
    end
  endtask

  task automatic test_cold();
    access(64'h0, 6, 4, 4'b1111, -1);
  endtask

  task automatic test_hits();
    access(64'h4, 0, 0, 4'b1111, -1);
    access(64'h8, 0, 0, 4'b1111, -1);
    access(64'hC, 0, 0, 4'b1111, -1);
  endtask

  task automatic test_conflict();
    access(64'h100, 6, 4, 4'b1111, -1);
    access(64'h108, 0, 0, 4'b1111, -1);
    access(64'h0, 6, 4, 4'b1111, -1);
  endtask

  task automatic test_wait_states();
    access(64'h2A0, 10, 4, 4'b1001, -1);
    access(64'h2A4, 0, 0, 4'b1111, -1);
    access(64'h2AC, 0, 0, 4'b1111, -1);
  endtask

  task automatic test_invalidate();
    access(64'h40, 12, 8, 4'b1111, 3);
    access(64'h48, 0, 0, 4'b1111, -1);
    access(64'h0, 6, 4, 4'b1111, -1);
  endtask

  task automatic test_reset_mid_refill();
    int b0;
    @(posedge clk); #1;
    bus.PCF = 64'h80;
    bus.memReady = 1'b1;
    bus.invalidate = 1'b0;
    addr_q.push_back(64'h80);
    addr_q.push_back(64'h84);
    b0 = beats;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (bus.memReq !== 1'b0 || bus.stallICache !== 1'b0 || bus.instrF !== 32'h00000013) begin
      bad++;
      $display("FAIL reset_abort: req=%b stall=%b instr=%h required 0 0 00000013", bus.memReq, bus.stallICache, bus.instrF);
    end
    total++;
    if (beats - b0 !== 2 || addr_q.size() != 0) begin
      bad++;
      $display("FAIL reset_partial: beats=%0d left=%0d required 2 0", beats - b0, addr_q.size());
    end
    addr_q.delete();
    repeat (2) @(posedge clk);
    access(64'h0, 6, 4, 4'b1111, -1);
    access(64'h80, 6, 4, 4'b1111, -1);
    access(64'h8C, 0, 0, 4'b1111, -1);
  endtask

  initial begin
    test_reset();
    test_cold();
    test_hits();
    test_conflict();
    test_wait_states();
    test_invalidate();
    test_reset_mid_refill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
